lcd_char_receiver: RTL and testbench
====================================

// Module: lcd_char_receiver
// PURPOSE
// - Receiving end of the HD44780-style 8-bit character-LCD bus that the LCD controller drives (LCD_E/RS/RW/DATA).
// - Decodes commands and data writes.
// - Maintains a 2x16 DDRAM mirror, an address counter and mode flags.
// - Enforces busy time and reports protocol errors.
// - Used as an on-chip bus checker/mirror and as the bench-side LCD model.
// PARAMETERS
// BUSY_CYCLES        2   clk cycles busy after any accepted command/data write (0 = never busy)
// CLEAR_BUSY_CYCLES  2   clk cycles busy after clear (0x01) or return-home (0x02/0x03)
// PORTS
// clk          in   1  system clock
// rst          in   1  asynchronous, active-low reset
// lcd_e        in   1  enable strobe, synchronous to clk
// lcd_rs       in   1  0 = instruction, 1 = data
// lcd_rw       in   1  0 = write, 1 = read
// lcd_data     in   8  bus data
// rd_line      in   1  mirror read line select (0 = top, 1 = bottom)
// rd_col       in   4  mirror read column
// rd_char      out  8  mirror character at {rd_line,rd_col}, registered, 1-cycle latency
// status_q     out  8  {busy, addr_ctr[6:0]}, updated on every RW=1 instruction read
// addr_ctr     out  7  DDRAM address counter
// display_on   out  1  D bit of last display-control command
// entry_inc    out  1  I/D bit of last entry-mode command
// two_line     out  1  N bit of last function-set command
// busy         out  1  busy window active
// frame_done   out  1  1-cycle pulse when return-home is accepted
// proto_err    out  1  1-cycle pulse: transfer arrived while busy
// err_count    out  8  saturating count of proto_err pulses
// BEHAVIOUR
// - Reset (rst=0):
//   - Mirror fills with 0x20; addr_ctr=0; display_on=0; entry_inc=1; two_line=0.
//   - busy=0; frame_done=0; proto_err=0; err_count=0; status_q=0; rd_char=0x20.
// - Strobe detect: register e_q, rs_q, rw_q, data_q every clk.
//   - A transfer occurs on the cycle with e_q=1 and lcd_e=0 (falling edge).
//   - The transfer uses rs_q/rw_q/data_q, the values held while E was high.
// - Transfer while busy=1: dropped, no state change, proto_err pulses, err_count++ (saturates at 255).
// - Exception: instruction reads (rs_q=0, rw_q=1) are always accepted and never start busy.
// - RS=0 RW=1: status_q <= {busy, addr_ctr}.
// - RS=1 RW=1: ignored, no busy.
// - Instruction decode (RS=0 RW=0), priority on highest set bit of data_q:
//   - 1xxxxxxx: addr_ctr <= data_q[6:0].
//   - 01xxxxxx: CGRAM address; accepted and ignored (busy still applies).
//   - 001xxxxx: two_line <= data_q[3]; DL/F bits ignored.
//   - 0001xxxx: if data_q[3]=0, cursor move: data_q[2]=1 inc else dec, using the wrap rules below.
//     If data_q[3]=1 (display shift): no effect.
//   - 00001xxx: display_on <= data_q[2]; C/B ignored.
//   - 000001xx: entry_inc <= data_q[1]; S ignored.
//   - 0000001x: addr_ctr <= 0; frame_done pulse; long busy.
//   - 00000001: mirror all 0x20; addr_ctr <= 0; entry_inc <= 1; long busy.
//   - 00000000: no-op, normal busy.
// - Data write (RS=1 RW=0):
//   - Store data_q at addr_ctr only if addr_ctr in 0x00-0x0F (line 0) or 0x40-0x4F (line 1).
//   - Then step addr_ctr by the entry_inc direction.
// - Address wrap (2-line map):
//   - inc: 0x27 -> 0x40; 0x67 -> 0x00.
//   - dec: 0x00 -> 0x67; 0x40 -> 0x27.
//   - Values 0x28-0x3F and 0x68-0x7F are only reachable by set-address; inc from them: +1 mod 128.
// - Busy: loads BUSY_CYCLES (or CLEAR_BUSY_CYCLES) on the accepting cycle; busy=1 while the counter is nonzero.
//   - A count of 0 means busy never asserts.
// - Simultaneous events:
//   - rd_char reads the pre-write value when its read hits the address written in the same cycle.
//   - Clear and write never coincide (one transfer per edge).
// - Reset mid-transfer: e_q clears, so no spurious edge is generated after reset release with lcd_e=0.
// STRUCTURE
// - lcd_pkg: opcode masks (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP, CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM),
//   LINE0_BASE=0x00, LINE1_BASE=0x40, LINE_END=0x27, CHAR_SPACE=0x20.
// - Sub-module lcd_ddram_mirror: 32x8 register file.
//   - One write port, synchronous clear-all, one registered read port.
// - Top level holds the strobe detector, decoder, address counter and busy/error logic.
// TESTING
// - Init 0x38,0x38,0x0C,0x01,0x06 (busy respected) -> two_line=1, display_on=1, entry_inc=1, addr_ctr=0,
//   mirror all 0x20, err_count=0.
// - 0x80 then "MODE : 24H TYPE " -> rd_line=0, col 0..15 read back 0x4D,0x4F,...,0x20; addr_ctr=0x10.
//   Then 0xC0 + 16 chars -> line 1 correct.
// - 0x8F, data 'A','B' -> col15='A', 'B' dropped, addr_ctr=0x11.
//   Then 0xA7, data 'C' -> addr_ctr=0x40, line 1 col 0 unchanged.
// - Entry 0x04, 0xC0, data 'X' -> line1 col0='X', addr_ctr=0x27.
//   Then 0x80, 0x10 (cursor left) -> addr_ctr=0x67.
// - With BUSY_CYCLES=4: data strobe 2 clks after prior accept -> dropped, proto_err 1 cycle, err_count=1.
//   Status read -> status_q[7]=1.
// - 0x02 -> frame_done one cycle, addr_ctr=0.
//   Assert rst mid-line -> all outputs at reset values; no transfer on release.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared opcode masks, DDRAM address map constants and address helpers
// for the HD44780-style bus receiver.
package lcd_pkg;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;
   localparam logic [7:0] CMD_ENTRY = 8'h04;
   localparam logic [7:0] CMD_DISP  = 8'h08;
   localparam logic [7:0] CMD_SHIFT = 8'h10;
   localparam logic [7:0] CMD_FUNC  = 8'h20;
   localparam logic [7:0] CMD_CGRAM = 8'h40;
   localparam logic [7:0] CMD_DDRAM = 8'h80;

   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam logic [6:0] LINE_END   = 7'h27;
   localparam logic [6:0] LINE1_END  = LINE1_BASE + LINE_END;
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   // Two-line DDRAM map: each line is 40 cells, the last cell of one line
   // wraps to the first of the other in both directions.
   function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
      if (inc)
         addr_step = (a == LINE_END)  ? LINE1_BASE :
                     (a == LINE1_END) ? LINE0_BASE : a + 7'd1;
      else
         addr_step = (a == LINE0_BASE) ? LINE1_END :
                     (a == LINE1_BASE) ? LINE_END  : a - 7'd1;
   endfunction

   function automatic logic addr_visible(input logic [6:0] a);
      addr_visible = (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
   endfunction

endpackage

// File: rtl/lcd_ddram_mirror.sv
// 2x16 character mirror: one write port, synchronous clear-all and a
// registered read port that returns the pre-write value on a collision.
module lcd_ddram_mirror
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic       clr,
   input  logic [4:0] waddr,
   input  logic [7:0] wdata,
   input  logic [4:0] raddr,
   output logic [7:0] rdata
);

   logic [31:0][7:0] mem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem   <= {32{CHAR_SPACE}};
         rdata <= CHAR_SPACE;
      end else begin
         rdata <= mem[raddr];
         if (clr)
            mem <= {32{CHAR_SPACE}};
         else if (we)
            mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/lcd_char_receiver.sv
// Receiving end of the 8-bit character-LCD bus: strobe detect, command
// decode, address counter, busy window and protocol-error reporting.
module lcd_char_receiver
   import lcd_pkg::*;
#(
   parameter int unsigned BUSY_CYCLES       = 2,
   parameter int unsigned CLEAR_BUSY_CYCLES = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic       rd_line,
   input  logic [3:0] rd_col,
   output logic [7:0] rd_char,
   output logic [7:0] status_q,
   output logic [6:0] addr_ctr,
   output logic       display_on,
   output logic       entry_inc,
   output logic       two_line,
   output logic       busy,
   output logic       frame_done,
   output logic       proto_err,
   output logic [7:0] err_count
);

   localparam logic [15:0] BUSY_LD  = 16'(BUSY_CYCLES);
   localparam logic [15:0] CLEAR_LD = 16'(CLEAR_BUSY_CYCLES);

   logic       e_q, rs_q, rw_q;
   logic [7:0] data_q;
   logic [15:0] busy_cnt;
   logic       xfer, inst_rd, accept, mir_we, mir_clr;

   assign busy    = (busy_cnt != 16'd0);
   assign xfer    = e_q && !lcd_e;
   assign inst_rd = !rs_q && rw_q;
   // Status reads bypass the busy check so a host can always poll.
   assign accept  = xfer && (!busy || inst_rd);

   always_comb begin
      mir_we  = 1'b0;
      mir_clr = 1'b0;
      if (accept && !rw_q) begin
         mir_we  = rs_q && addr_visible(addr_ctr);
         mir_clr = !rs_q && (data_q == CMD_CLEAR);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_q        <= 1'b0;
         rs_q       <= 1'b0;
         rw_q       <= 1'b0;
         data_q     <= 8'h00;
         busy_cnt   <= 16'd0;
         addr_ctr   <= LINE0_BASE;
         display_on <= 1'b0;
         entry_inc  <= 1'b1;
         two_line   <= 1'b0;
         status_q   <= 8'h00;
         frame_done <= 1'b0;
         proto_err  <= 1'b0;
         err_count  <= 8'h00;
      end else begin
         e_q        <= lcd_e;
         rs_q       <= lcd_rs;
         rw_q       <= lcd_rw;
         data_q     <= lcd_data;
         frame_done <= 1'b0;
         proto_err  <= 1'b0;
         if (busy)
            busy_cnt <= busy_cnt - 16'd1;

         if (xfer && !accept) begin
            proto_err <= 1'b1;
            if (err_count != 8'hFF)
               err_count <= err_count + 8'd1;
         end else if (accept) begin
            case ({rs_q, rw_q})
               2'b01: status_q <= {busy, addr_ctr};
               2'b11: ;
               2'b10: begin
                  addr_ctr <= addr_step(addr_ctr, entry_inc);
                  busy_cnt <= BUSY_LD;
               end
               default: begin
                  busy_cnt <= BUSY_LD;
                  if ((data_q & CMD_DDRAM) != 8'h00)
                     addr_ctr <= data_q[6:0];
                  else if ((data_q & CMD_CGRAM) != 8'h00)
                     ;
                  else if ((data_q & CMD_FUNC) != 8'h00)
                     two_line <= data_q[3];
                  else if ((data_q & CMD_SHIFT) != 8'h00) begin
                     if (!data_q[3])
                        addr_ctr <= addr_step(addr_ctr, data_q[2]);
                  end else if ((data_q & CMD_DISP) != 8'h00)
                     display_on <= data_q[2];
                  else if ((data_q & CMD_ENTRY) != 8'h00)
                     entry_inc <= data_q[1];
                  else if ((data_q & CMD_HOME) != 8'h00) begin
                     addr_ctr   <= LINE0_BASE;
                     frame_done <= 1'b1;
                     busy_cnt   <= CLEAR_LD;
                  end else if (data_q == CMD_CLEAR) begin
                     addr_ctr  <= LINE0_BASE;
                     entry_inc <= 1'b1;
                     busy_cnt  <= CLEAR_LD;
                  end
               end
            endcase
         end
      end
   end

   lcd_ddram_mirror u_mirror (
      .clk   (clk),
      .rst   (rst),
      .we    (mir_we),
      .clr   (mir_clr),
      .waddr ({addr_ctr[6], addr_ctr[3:0]}),
      .wdata (data_q),
      .raddr ({rd_line, rd_col}),
      .rdata (rd_char)
   );

endmodule

// File: tb/tb_lcd_char_receiver.sv
// Directed bench for lcd_char_receiver: init sequence, line writes, address
// wrap, busy violations, home/clear and reset during a transfer.
module tb_lcd_char_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic       rd_line = 1'b0;
   logic [3:0] rd_col = 4'h0;
   logic [7:0] rd_char, status_q, err_count;
   logic [6:0] addr_ctr;
   logic       display_on, entry_inc, two_line, busy, frame_done, proto_err;

   int n_vec = 0;
   int n_bad = 0;

   string s0 = "MODE : 24H TYPE ";
   string s1 = "LINE-2 MIRROR OK";

   lcd_char_receiver #(.BUSY_CYCLES(4), .CLEAR_BUSY_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_data(lcd_data), .rd_line(rd_line), .rd_col(rd_col), .rd_char(rd_char),
      .status_q(status_q), .addr_ctr(addr_ctr), .display_on(display_on),
      .entry_inc(entry_inc), .two_line(two_line), .busy(busy),
      .frame_done(frame_done), .proto_err(proto_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge right after the transfer edge.
   task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
      lcd_e = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
      @(negedge clk);
      lcd_e = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (busy) chk("idle_timeout", {15'd0, busy}, 16'd0);
   endtask

   task automatic cmd(input logic [7:0] d);
      strobe(1'b0, 1'b0, d);
      wait_idle();
   endtask

   task automatic wr(input logic [7:0] d);
      strobe(1'b1, 1'b0, d);
      wait_idle();
   endtask

   task automatic rd(input string tag, input logic ln, input logic [3:0] col, input logic [7:0] exp);
      rd_line = ln; rd_col = col;
      @(negedge clk);
      chk(tag, {8'd0, rd_char}, {8'd0, exp});
   endtask

   initial begin
      logic [7:0] c;
      repeat (2) @(negedge clk);
      chk("rst_addr",    {9'd0, addr_ctr}, 16'h0000);
      chk("rst_entry",   {15'd0, entry_inc}, 16'd1);
      chk("rst_disp",    {15'd0, display_on}, 16'd0);
      chk("rst_2line",   {15'd0, two_line}, 16'd0);
      chk("rst_busy",    {15'd0, busy}, 16'd0);
      chk("rst_status",  {8'd0, status_q}, 16'h0000);
      chk("rst_rdchar",  {8'd0, rd_char}, 16'h0020);
      chk("rst_errcnt",  {8'd0, err_count}, 16'h0000);
      rst = 1'b1;
      @(negedge clk);

      cmd(8'h38); cmd(8'h38); cmd(8'h0C); cmd(8'h01); cmd(8'h06);
      chk("init_2line", {15'd0, two_line}, 16'd1);
      chk("init_disp",  {15'd0, display_on}, 16'd1);
      chk("init_entry", {15'd0, entry_inc}, 16'd1);
      chk("init_addr",  {9'd0, addr_ctr}, 16'h0000);
      chk("init_err",   {8'd0, err_count}, 16'h0000);
      rd("init_l0c5", 1'b0, 4'd5, 8'h20);
      rd("init_l1c9", 1'b1, 4'd9, 8'h20);

      cmd(8'h80);
      for (int i = 0; i < 16; i++) wr(s0[i]);
      chk("l0_addr", {9'd0, addr_ctr}, 16'h0010);
      for (int i = 0; i < 16; i++) begin
         c = s0[i];
         rd("l0_char", 1'b0, 4'(i), c);
      end
      cmd(8'hC0);
      for (int i = 0; i < 16; i++) wr(s1[i]);
      chk("l1_addr", {9'd0, addr_ctr}, 16'h0050);
      for (int i = 0; i < 16; i++) begin
         c = s1[i];
         rd("l1_char", 1'b1, 4'(i), c);
      end

      cmd(8'h8F); wr(8'h41); wr(8'h42);
      rd("col15_A", 1'b0, 4'd15, 8'h41);
      chk("off_addr", {9'd0, addr_ctr}, 16'h0011);
      cmd(8'hA7); wr(8'h43);
      chk("wrap_inc", {9'd0, addr_ctr}, 16'h0040);
      c = s1[0];
      rd("l1c0_keep", 1'b1, 4'd0, c);

      cmd(8'h04);
      chk("entry_dec", {15'd0, entry_inc}, 16'd0);
      cmd(8'hC0); wr(8'h58);
      rd("l1c0_X", 1'b1, 4'd0, 8'h58);
      chk("wrap_dec1", {9'd0, addr_ctr}, 16'h0027);
      cmd(8'h80); cmd(8'h10);
      chk("wrap_dec0", {9'd0, addr_ctr}, 16'h0067);

      strobe(1'b0, 1'b1, 8'h00);
      chk("stat_idle", {8'd0, status_q}, 16'h0067);
      strobe(1'b0, 1'b0, 8'h0C);
      strobe(1'b1, 1'b0, 8'h51);
      chk("perr_pulse", {15'd0, proto_err}, 16'd1);
      chk("perr_cnt",   {8'd0, err_count}, 16'h0001);
      chk("perr_addr",  {9'd0, addr_ctr}, 16'h0067);
      strobe(1'b0, 1'b1, 8'h00);
      chk("stat_busy",  {8'd0, status_q}, 16'h00E7);
      chk("perr_clr",   {15'd0, proto_err}, 16'd0);
      wait_idle();

      strobe(1'b0, 1'b0, 8'h02);
      chk("home_pulse", {15'd0, frame_done}, 16'd1);
      chk("home_addr",  {9'd0, addr_ctr}, 16'h0000);
      @(negedge clk);
      chk("home_end",   {15'd0, frame_done}, 16'd0);
      wait_idle();

      cmd(8'h01);
      chk("clr_entry", {15'd0, entry_inc}, 16'd1);
      rd("clr_l0c15", 1'b0, 4'd15, 8'h20);
      rd("clr_l1c0",  1'b1, 4'd0, 8'h20);

      cmd(8'h80); wr(8'h5A);
      rd("pre_rst_Z", 1'b0, 4'd0, 8'h5A);
      lcd_e = 1'b1; lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h59;
      @(negedge clk);
      rst = 1'b0;
      lcd_e = 1'b0;
      #1;
      chk("mid_addr",   {9'd0, addr_ctr}, 16'h0000);
      chk("mid_disp",   {15'd0, display_on}, 16'd0);
      chk("mid_2line",  {15'd0, two_line}, 16'd0);
      chk("mid_err",    {8'd0, err_count}, 16'h0000);
      chk("mid_rdchar", {8'd0, rd_char}, 16'h0020);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_addr", {9'd0, addr_ctr}, 16'h0000);
      chk("post_busy", {15'd0, busy}, 16'd0);
      rd("post_l0c0", 1'b0, 4'd0, 8'h20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
